csi_rx_frame_ctrl: RTL

- Sequencing controller for the CSI-2 RX packet handler and its upstream word aligner.
- Gates the handler's enable and waits for aligner lock.
- After every packet, pulses the aligner reset to force re-alignment; a watchdog recovers from stuck packets.
- Derives line/frame timing (line_start, line_end, frame_start, line counts) from handler status, because the handler forwards only RAW8 payload and drops FS/FE short packets. Sits between the CSI RX front end and the HDMI-side line buffer.

---
 rtl/csi_rx_pkg.sv | 16 +
 rtl/csi_rx_line_timer.sv | 93 +++++++++
 rtl/csi_rx_frame_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/csi_rx_pkg.sv
// Shared types and constants for the CSI-2 RX sequencing controller.
package csi_rx_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_LOCK_WAIT = 2'd1,
    ST_RUN       = 2'd2,
    ST_RESYNC    = 2'd3
  } ctrl_state_t;

  // Data type of the only payload the handler forwards.
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  localparam int DEFAULT_NUM_LANES = 2;

endpackage

// File: rtl/csi_rx_line_timer.sv
// Line/frame timing recovered from handler payload and end-of-packet strobes.
// Inputs arrive already qualified by the controller (RUN state, enable high).
module csi_rx_line_timer
  import csi_rx_pkg::*;
#(
  parameter int NUM_LANES  = DEFAULT_NUM_LANES,
  parameter int VBLANK_MIN = 4096,
  parameter int LINE_W     = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pv_run,
  input  logic              pd_run,
  input  logic              abort,
  input  logic              go_off,
  output logic              line_start,
  output logic              line_end,
  output logic              frame_start,
  output logic [15:0]       line_bytes,
  output logic [LINE_W-1:0] line_index,
  output logic [LINE_W-1:0] frame_lines
);

  localparam int GAP_W = $clog2(VBLANK_MIN + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(VBLANK_MIN);
  localparam logic [16:0]      LANE_INC = 17'(NUM_LANES);

  logic [15:0]      acc;
  logic [16:0]      acc_sum;
  logic [15:0]      acc_add;
  logic [GAP_W-1:0] gap;
  logic             first_frame;
  logic             new_line;
  logic             new_frame;
  logic             line_done;

  // Saturating byte add and line/frame event decode.
  always_comb begin
    acc_sum   = {1'b0, acc} + LANE_INC;
    acc_add   = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    new_line  = pv_run && (acc == 16'd0);
    new_frame = new_line && ((gap == GAP_MAX) || first_frame);
    line_done = pd_run && (acc != 16'd0);
  end

  // Accumulator, gap counter and line/frame bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      gap         <= '0;
      first_frame <= 1'b1;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      line_bytes  <= '0;
      line_index  <= '0;
      frame_lines <= '0;
    end else begin
      line_start  <= new_line;
      frame_start <= new_frame;
      line_end    <= line_done;

      if (go_off || abort || line_done)
        acc <= '0;
      else if (pv_run)
        acc <= acc_add;

      if (line_done)
        line_bytes <= acc;

      if (new_frame)
        line_index <= '0;
      else if (line_done)
        line_index <= line_index + 1'b1;

      // line_index has already advanced past the final line by its line_end,
      // so it holds the number of lines completed in the frame.
      if (new_frame && !first_frame)
        frame_lines <= line_index;

      if (go_off)
        first_frame <= 1'b1;
      else if (new_frame)
        first_frame <= 1'b0;

      if (line_done || new_frame)
        gap <= '0;
      else if (gap != GAP_MAX)
        gap <= gap + 1'b1;
    end
  end

endmodule

// File: rtl/csi_rx_frame_ctrl.sv
// Sequencing controller for the CSI-2 RX packet handler and word aligner:
// enable gating, lock wait, per-packet aligner re-sync and a stuck-packet
// watchdog. Line/frame timing lives in csi_rx_line_timer.
module csi_rx_frame_ctrl
  import csi_rx_pkg::*;
#(
  parameter int NUM_LANES     = DEFAULT_NUM_LANES,
  parameter int RESYNC_CYCLES = 4,
  parameter int PKT_TIMEOUT   = 16384,
  parameter int VBLANK_MIN    = 4096,
  parameter int LINE_W        = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_enable,
  input  logic              aligner_locked,
  input  logic              sync_wait,
  input  logic              packet_done,
  input  logic              payload_valid,
  output logic              handler_enable,
  output logic              aligner_reset,
  output logic              line_start,
  output logic              line_end,
  output logic              frame_start,
  output logic [15:0]       line_bytes,
  output logic [LINE_W-1:0] line_index,
  output logic [LINE_W-1:0] frame_lines,
  output logic              timeout_err
);

  localparam int RS_W = $clog2(RESYNC_CYCLES + 1);
  localparam int WD_W = $clog2(PKT_TIMEOUT + 1);
  localparam logic [RS_W-1:0] RS_LOAD = RS_W'(RESYNC_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(PKT_TIMEOUT - 1);

  ctrl_state_t     state;
  ctrl_state_t     state_nxt;
  logic [RS_W-1:0] rs_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            run;
  logic            wd_expire;

  assign run       = (state == ST_RUN);
  assign wd_expire = run && !sync_wait && (wd_cnt == WD_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_OFF;
    else       state <= state_nxt;
  end

  // Next-state logic; software disable overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:       if (ctrl_enable) state_nxt = ST_LOCK_WAIT;
      ST_LOCK_WAIT: if (aligner_locked) state_nxt = ST_RUN;
      ST_RUN:       if (packet_done || wd_expire) state_nxt = ST_RESYNC;
      ST_RESYNC:    if (rs_cnt == '0) state_nxt = ST_LOCK_WAIT;
      default:      state_nxt = ST_OFF;
    endcase
    if (!ctrl_enable) state_nxt = ST_OFF;
  end

  // Re-sync length counter, loaded on entry to RESYNC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rs_cnt <= '0;
    else if (state_nxt == ST_RESYNC && state != ST_RESYNC)
      rs_cnt <= RS_LOAD;
    else if (rs_cnt != '0)
      rs_cnt <= rs_cnt - 1'b1;
  end

  // Watchdog: consecutive RUN cycles without the handler returning to idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (run && !sync_wait)
      wd_cnt <= wd_cnt + 1'b1;
    else
      wd_cnt <= '0;
  end

  // Registered FSM outputs and sticky timeout flag; a same-cycle packet_done
  // is a normal packet end and does not count as a timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      handler_enable <= 1'b0;
      aligner_reset  <= 1'b1;
      timeout_err    <= 1'b0;
    end else begin
      handler_enable <= (state_nxt == ST_RUN) || (state_nxt == ST_RESYNC);
      aligner_reset  <= (state_nxt == ST_OFF) || (state_nxt == ST_RESYNC);
      if (wd_expire && !packet_done && ctrl_enable)
        timeout_err <= 1'b1;
    end
  end

  csi_rx_line_timer #(
    .NUM_LANES  (NUM_LANES),
    .VBLANK_MIN (VBLANK_MIN),
    .LINE_W     (LINE_W)
  ) u_line_timer (
    .clock       (clock),
    .reset       (reset),
    .pv_run      (run && ctrl_enable && payload_valid),
    .pd_run      (run && ctrl_enable && packet_done),
    .abort       (wd_expire && ctrl_enable && !packet_done),
    .go_off      (!ctrl_enable),
    .line_start  (line_start),
    .line_end    (line_end),
    .frame_start (frame_start),
    .line_bytes  (line_bytes),
    .line_index  (line_index),
    .frame_lines (frame_lines)
  );

endmodule
